// File: rtl/state_readout_pkg.sv
// state_readout_pkg: shared complex amplitude type, Q-format constants and
// the readout FSM state type used across the state readout slice.
package state_readout_pkg;

   // One amplitude: a = real part, b = imaginary part, each Q2.6 two's complement.
   typedef struct packed {
      logic signed [7:0] a;
      logic signed [7:0] b;
   } complexNum;

   // 1.0 in amplitude format (Q2.6) and in probability format (Q4.12).
   localparam logic [7:0]  ONE      = 8'h40;
   localparam logic [15:0] PROB_ONE = 16'h1000;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      SEND,
      FIN
   } state_t;

endpackage

// File: rtl/state_readout_if.sv
// state_readout_if: capture handshake for a full state vector plus the
// per-amplitude output stream and end-of-readout summary.
interface state_readout_if
   import state_readout_pkg::*;
#(
   parameter int N = 1
) ();

   logic                  in_valid;
   logic                  in_ready;
   complexNum [2**N-1:0]  in_state;
   logic                  out_valid;
   logic                  out_ready;
   logic [N-1:0]          out_index;
   complexNum             out_amp;
   logic [15:0]           out_prob;
   logic                  out_last;
   logic                  done;
   logic [15+N:0]         norm_sum;

   // Producer/consumer side of the readout.
   modport master (
      output in_valid,
      output in_state,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_index,
      input  out_amp,
      input  out_prob,
      input  out_last,
      input  done,
      input  norm_sum
   );

   // The readout block itself.
   modport slave (
      input  in_valid,
      input  in_state,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_index,
      output out_amp,
      output out_prob,
      output out_last,
      output done,
      output norm_sum
   );

endinterface

// File: rtl/state_readout_mag_sq.sv
// complex_mag_sq: combinational |z|^2 = a*a + b*b of a Q2.6 amplitude,
// returned as unsigned Q4.12. Each square is formed at full signed width so
// -128*-128 = 16384 is exact, and the largest possible sum (16'h8000) still
// fits in 16 unsigned bits.
module complex_mag_sq
   import state_readout_pkg::*;
(
   input  complexNum   z,
   output logic [15:0] mag_sq
);

   logic signed [15:0] re_sq;
   logic signed [15:0] im_sq;

   // Square both parts at 16-bit signed width, then add as unsigned values.
   always_comb begin
      re_sq  = 16'(z.a) * 16'(z.a);
      im_sq  = 16'(z.b) * 16'(z.b);
      mag_sq = $unsigned(re_sq) + $unsigned(im_sq);
   end

endmodule

// File: rtl/state_readout.sv
// state_readout: captures a parallel 2**N amplitude state vector, then streams
// it out one basis state per beat with its probability, and finally reports
// the accumulated probability sum (should be ~PROB_ONE for a normalized state).
module state_readout
   import state_readout_pkg::*;
#(
   parameter int N = 1
) (
   input logic            clk,
   input logic            reset,
   state_readout_if.slave bus
);

   localparam int            DEPTH    = 2**N;
   localparam logic [N-1:0]  LAST_IDX = '1;

   state_t                state;
   complexNum [DEPTH-1:0] vec;
   logic [N-1:0]          idx;
   logic [15+N:0]         sum;
   complexNum             amp_q;
   logic [15:0]           prob_q;
   logic                  valid_q;
   logic                  last_q;
   logic                  done_q;
   logic                  ready_q;
   logic [15:0]           prob_calc;

   complex_mag_sq u_mag_sq (
      .z      (vec[idx]),
      .mag_sq (prob_calc)
   );

   // Readout FSM: capture in IDLE, compute one beat in CALC, hold it in SEND
   // until accepted, and pulse done in FIN before returning to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         vec     <= '0;
         idx     <= '0;
         sum     <= '0;
         amp_q   <= '0;
         prob_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.in_valid) begin
                  vec     <= bus.in_state;
                  idx     <= '0;
                  sum     <= '0;
                  ready_q <= 1'b0;
                  state   <= CALC;
               end
            end
            CALC: begin
               amp_q   <= vec[idx];
               prob_q  <= prob_calc;
               last_q  <= (idx == LAST_IDX);
               sum     <= sum + {{N{1'b0}}, prob_calc};
               valid_q <= 1'b1;
               state   <= SEND;
            end
            SEND: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  if (last_q) begin
                     done_q <= 1'b1;
                     state  <= FIN;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= CALC;
                  end
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = ready_q;
   assign bus.out_valid = valid_q;
   assign bus.out_index = idx;
   assign bus.out_amp   = amp_q;
   assign bus.out_prob  = prob_q;
   assign bus.out_last  = last_q;
   assign bus.done      = done_q;
   assign bus.norm_sum  = sum;

endmodule

// File: tb/tb_state_readout.sv
// tb_state_readout: drives an N=1 and an N=2 readout instance with directed
// and random state vectors, predicting each beat, its timing and the final
// probability sum from a plain arithmetic model of |z|^2.
module tb_state_readout;
   import state_readout_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   // Stimulus drivers shared by both instances; sel picks the active one.
   int               sel;
   logic             in_valid_drv;
   logic             ready_drv;
   complexNum [3:0]  vec_drv;

   // Observation of the selected instance, widened to the N=2 shape.
   logic             o_valid;
   logic             o_in_ready;
   logic [1:0]       o_index;
   complexNum        o_amp;
   logic [15:0]      o_prob;
   logic             o_last;
   logic             o_done;
   logic [17:0]      o_sum;

   // Results recorded by run_stream.
   int               n_beats;
   logic [1:0]       b_idx  [8];
   complexNum        b_amp  [8];
   logic [15:0]      b_prob [8];
   logic             b_last [8];
   int               b_cyc  [8];
   int               done_count;
   int               done_cyc;
   logic [17:0]      done_sum;
   int               cap_cyc;
   logic             cap_ready;

   state_readout_if #(.N(1)) bus1 ();
   state_readout_if #(.N(2)) bus2 ();

   state_readout #(.N(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   state_readout #(.N(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   // Cycle counter used to check beat and done timing.
   always @(posedge clk) cyc <= cyc + 1;

   assign bus1.in_valid  = in_valid_drv && (sel == 0);
   assign bus2.in_valid  = in_valid_drv && (sel == 1);
   assign bus1.in_state  = vec_drv[1:0];
   assign bus2.in_state  = vec_drv;
   assign bus1.out_ready = ready_drv;
   assign bus2.out_ready = ready_drv;

   assign o_valid    = (sel == 1) ? bus2.out_valid : bus1.out_valid;
   assign o_in_ready = (sel == 1) ? bus2.in_ready  : bus1.in_ready;
   assign o_index    = (sel == 1) ? bus2.out_index : {1'b0, bus1.out_index};
   assign o_amp      = (sel == 1) ? bus2.out_amp   : bus1.out_amp;
   assign o_prob     = (sel == 1) ? bus2.out_prob  : bus1.out_prob;
   assign o_last     = (sel == 1) ? bus2.out_last  : bus1.out_last;
   assign o_done     = (sel == 1) ? bus2.done      : bus1.done;
   assign o_sum      = (sel == 1) ? bus2.norm_sum  : {1'b0, bus1.norm_sum};

   // Reference: probability of an amplitude is re^2 + im^2 in integer units.
   function automatic int exp_prob(complexNum z);
      int re;
      int im;
      re = $signed(z.a);
      im = $signed(z.b);
      return re * re + im * im;
   endfunction

   function automatic complexNum rand_amp();
      complexNum z;
      z.a = 8'($urandom);
      z.b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) z.a = 8'h80;
      return z;
   endfunction

   task automatic capture(input int s, input complexNum [3:0] v);
      @(negedge clk);
      sel          = s;
      vec_drv      = v;
      in_valid_drv = 1'b1;
      #1;
      cap_ready = o_in_ready;
      cap_cyc   = cyc;
      @(negedge clk);
      in_valid_drv = 1'b0;
   endtask

   task automatic run_stream(input int budget);
      n_beats    = 0;
      done_count = 0;
      done_cyc   = -100;
      done_sum   = '0;
      ready_drv  = 1'b1;
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         if (o_valid === 1'b1 && n_beats < 8) begin
            b_idx[n_beats]  = o_index;
            b_amp[n_beats]  = o_amp;
            b_prob[n_beats] = o_prob;
            b_last[n_beats] = o_last;
            b_cyc[n_beats]  = cyc;
            n_beats++;
         end
         if (o_done === 1'b1) begin
            done_count++;
            done_sum = o_sum;
            done_cyc = cyc;
         end
         if (done_count > 0 && cyc > done_cyc) break;
      end
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      in_valid_drv = 1'b0;
      ready_drv    = 1'b0;
      vec_drv      = '0;
      sel          = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         checks++; if (o_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready[%0d]: got %b expected 1", s, o_in_ready); end
         checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid[%0d]: got %b expected 0", s, o_valid); end
         checks++; if (o_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done[%0d]: got %b expected 0", s, o_done); end
         checks++; if (o_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_last[%0d]: got %b expected 0", s, o_last); end
         checks++; if (o_index !== 2'd0) begin errors++; $display("[TB] FAIL rst_index[%0d]: got %h expected 0", s, o_index); end
         checks++; if (o_prob !== 16'h0) begin errors++; $display("[TB] FAIL rst_prob[%0d]: got %h expected 0", s, o_prob); end
         checks++; if (o_amp !== 16'h0) begin errors++; $display("[TB] FAIL rst_amp[%0d]: got %h expected 0", s, o_amp); end
         checks++; if (o_sum !== 18'h0) begin errors++; $display("[TB] FAIL rst_sum[%0d]: got %h expected 0", s, o_sum); end
      end
   endtask

   task automatic test_streams();
      complexNum [3:0] v;
      int m;
      int exp_sum;
      logic el;
      for (int s = 0; s < 2; s++) begin
         for (int t = 0; t < 5; t++) begin
            m = (s == 0) ? 2 : 4;
            for (int k = 0; k < 4; k++) v[k] = rand_amp();
            if (s == 0 && t == 0) begin
               v    = '0;
               v[0] = {8'h20, 8'h20};
            end
            if (s == 0 && t == 1) begin
               v    = '0;
               v[0] = {ONE, 8'h00};
               v[1] = {8'hC0, 8'h00};
            end
            if (s == 1 && t == 0) begin
               for (int k = 0; k < 4; k++) v[k] = {8'h80, 8'h80};
            end
            ready_drv = 1'b1;
            capture(s, v);
            run_stream(40);
            exp_sum = 0;
            for (int k = 0; k < m; k++) exp_sum += exp_prob(v[k]);
            checks++; if (cap_ready !== 1'b1) begin errors++; $display("[TB] FAIL st_in_ready[%0d.%0d]: got %b expected 1", s, t, cap_ready); end
            checks++; if (n_beats != m) begin errors++; $display("[TB] FAIL st_beats[%0d.%0d]: got %0d expected %0d", s, t, n_beats, m); end
            for (int k = 0; k < m && k < n_beats; k++) begin
               el = (k == m - 1);
               checks++; if (b_idx[k] !== 2'(k)) begin errors++; $display("[TB] FAIL st_idx[%0d.%0d.%0d]: got %0d expected %0d", s, t, k, b_idx[k], k); end
               checks++; if (b_prob[k] !== 16'(exp_prob(v[k]))) begin errors++; $display("[TB] FAIL st_prob[%0d.%0d.%0d]: got %h expected %h", s, t, k, b_prob[k], 16'(exp_prob(v[k]))); end
               checks++; if (b_amp[k] !== v[k]) begin errors++; $display("[TB] FAIL st_amp[%0d.%0d.%0d]: got %h expected %h", s, t, k, b_amp[k], v[k]); end
               checks++; if (b_last[k] !== el) begin errors++; $display("[TB] FAIL st_last[%0d.%0d.%0d]: got %b expected %b", s, t, k, b_last[k], el); end
               checks++; if (b_cyc[k] != cap_cyc + 2 + 2 * k) begin errors++; $display("[TB] FAIL st_beat_time[%0d.%0d.%0d]: got %0d expected %0d", s, t, k, b_cyc[k] - cap_cyc, 2 + 2 * k); end
            end
            checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL st_done_count[%0d.%0d]: got %0d expected 1", s, t, done_count); end
            checks++; if (done_sum !== 18'(exp_sum)) begin errors++; $display("[TB] FAIL st_norm_sum[%0d.%0d]: got %h expected %h", s, t, done_sum, 18'(exp_sum)); end
            checks++; if (done_cyc != cap_cyc + 2 * m + 1) begin errors++; $display("[TB] FAIL st_done_time[%0d.%0d]: got %0d expected %0d", s, t, done_cyc - cap_cyc, 2 * m + 1); end
         end
      end
   endtask

   task automatic test_backpressure();
      complexNum [3:0] v;
      int   exp_sum;
      int   p0;
      logic found;
      for (int k = 0; k < 4; k++) v[k] = rand_amp();
      p0      = exp_prob(v[0]);
      exp_sum = 0;
      for (int k = 0; k < 4; k++) exp_sum += exp_prob(v[k]);
      ready_drv = 1'b0;
      capture(1, v);
      found = 1'b0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (o_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_valid: got %b expected 1 within 10 cycles", found); end
      for (int s = 0; s < 6; s++) begin
         if (s > 0) @(negedge clk);
         checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", s, o_valid); end
         checks++; if (o_index !== 2'd0) begin errors++; $display("[TB] FAIL bp_index[%0d]: got %0d expected 0", s, o_index); end
         checks++; if (o_prob !== 16'(p0)) begin errors++; $display("[TB] FAIL bp_prob[%0d]: got %h expected %h", s, o_prob, 16'(p0)); end
         checks++; if (o_amp !== v[0]) begin errors++; $display("[TB] FAIL bp_amp[%0d]: got %h expected %h", s, o_amp, v[0]); end
         checks++; if (o_last !== 1'b0) begin errors++; $display("[TB] FAIL bp_last[%0d]: got %b expected 0", s, o_last); end
      end
      ready_drv = 1'b1;
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_accept: got valid %b expected 0 after first ready", o_valid); end
      run_stream(40);
      checks++; if (n_beats != 3) begin errors++; $display("[TB] FAIL bp_beats: got %0d expected 3", n_beats); end
      if (n_beats > 0) begin
         checks++; if (b_idx[0] !== 2'd1) begin errors++; $display("[TB] FAIL bp_next_idx: got %0d expected 1", b_idx[0]); end
      end
      checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL bp_done_count: got %0d expected 1", done_count); end
      checks++; if (done_sum !== 18'(exp_sum)) begin errors++; $display("[TB] FAIL bp_norm_sum: got %h expected %h", done_sum, 18'(exp_sum)); end
   endtask

   task automatic test_ignore_input();
      complexNum [3:0] v;
      complexNum [3:0] w;
      int p0;
      int p1;
      for (int k = 0; k < 4; k++) v[k] = rand_amp();
      w  = v ^ 64'h5a5a_a5a5_3c3c_c3c3;
      p0 = exp_prob(v[0]);
      p1 = exp_prob(v[1]);
      ready_drv = 1'b1;
      capture(0, v);
      @(negedge clk);
      checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL ig_valid: got %b expected 1", o_valid); end
      checks++; if (o_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ig_in_ready: got %b expected 0", o_in_ready); end
      checks++; if (o_amp !== v[0]) begin errors++; $display("[TB] FAIL ig_amp0: got %h expected %h", o_amp, v[0]); end
      checks++; if (o_prob !== 16'(p0)) begin errors++; $display("[TB] FAIL ig_prob0: got %h expected %h", o_prob, 16'(p0)); end
      vec_drv      = w;
      in_valid_drv = 1'b1;
      @(negedge clk);
      in_valid_drv = 1'b0;
      run_stream(40);
      checks++; if (n_beats != 1) begin errors++; $display("[TB] FAIL ig_beats: got %0d expected 1", n_beats); end
      checks++; if (b_amp[0] !== v[1]) begin errors++; $display("[TB] FAIL ig_amp1: got %h expected %h", b_amp[0], v[1]); end
      checks++; if (b_prob[0] !== 16'(p1)) begin errors++; $display("[TB] FAIL ig_prob1: got %h expected %h", b_prob[0], 16'(p1)); end
      checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL ig_done_count: got %0d expected 1", done_count); end
      checks++; if (done_sum !== 18'(p0 + p1)) begin errors++; $display("[TB] FAIL ig_norm_sum: got %h expected %h", done_sum, 18'(p0 + p1)); end
   endtask

   task automatic test_mid_reset();
      complexNum [3:0] v;
      int extra_done;
      int exp_sum;
      for (int k = 0; k < 4; k++) v[k] = rand_amp();
      v[0]      = {ONE, ONE};
      ready_drv = 1'b1;
      capture(0, v);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (o_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mr_in_ready: got %b expected 1", o_in_ready); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL mr_valid: got %b expected 0", o_valid); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("[TB] FAIL mr_done: got %b expected 0", o_done); end
      checks++; if (o_last !== 1'b0) begin errors++; $display("[TB] FAIL mr_last: got %b expected 0", o_last); end
      checks++; if (o_index !== 2'd0) begin errors++; $display("[TB] FAIL mr_index: got %0d expected 0", o_index); end
      checks++; if (o_prob !== 16'h0) begin errors++; $display("[TB] FAIL mr_prob: got %h expected 0", o_prob); end
      checks++; if (o_amp !== 16'h0) begin errors++; $display("[TB] FAIL mr_amp: got %h expected 0", o_amp); end
      checks++; if (o_sum !== 18'h0) begin errors++; $display("[TB] FAIL mr_sum: got %h expected 0", o_sum); end
      extra_done = 0;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         if (o_done !== 1'b0 || o_valid !== 1'b0) extra_done++;
      end
      checks++; if (extra_done != 0) begin errors++; $display("[TB] FAIL mr_quiet: got %0d active cycles expected 0", extra_done); end
      for (int k = 0; k < 4; k++) v[k] = rand_amp();
      exp_sum = exp_prob(v[0]) + exp_prob(v[1]);
      capture(0, v);
      run_stream(40);
      checks++; if (n_beats != 2) begin errors++; $display("[TB] FAIL mr_fresh_beats: got %0d expected 2", n_beats); end
      checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL mr_fresh_done: got %0d expected 1", done_count); end
      checks++; if (done_sum !== 18'(exp_sum)) begin errors++; $display("[TB] FAIL mr_fresh_sum: got %h expected %h", done_sum, 18'(exp_sum)); end
   endtask

   initial begin
      $display("[TB] starting state_readout bench");
      test_reset();
      test_streams();
      test_backpressure();
      test_ignore_input();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
